// File: rtl/serial_to_parallel_align.sv
// Receive-side deserializer: hunts for COM symbols in the serial stream and locks byte alignment.
// Optional byte counter port enabled by defining STOS_BYTE_CNT_EN.
module serial_to_parallel_align #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM_SYMBOL = 8'hBC,
    parameter int               LOCK_COUNT = 4
) (
    input  logic             clk32f,
    input  logic             reset,
    input  logic             in,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             active
`ifdef STOS_BYTE_CNT_EN
    ,
    output logic [7:0]       byte_cnt
`endif
);

    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ALIGNING = 2'd1,
        ACTIVE   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [3:0]       com_cnt_q, com_cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             active_q, active_d;
    logic             boundary;
    logic             is_com;
    logic [BCW-1:0]   bit_cnt_inc;

`ifdef STOS_BYTE_CNT_EN
    logic [7:0]       byte_cnt_q, byte_cnt_d;
`endif

    // sr_d is the shift register value after this edge; all decisions look at it
    assign sr_d        = {sr_q[WIDTH-2:0], in};
    assign is_com      = (sr_d == COM_SYMBOL);
    assign boundary    = (bit_cnt_q == BCW'(WIDTH - 1));
    assign bit_cnt_inc = boundary ? '0 : bit_cnt_q + BCW'(1);

    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            state_q     <= UNLOCKED;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            com_cnt_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            active_q    <= 1'b0;
`ifdef STOS_BYTE_CNT_EN
            byte_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            com_cnt_q   <= com_cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            active_q    <= active_d;
`ifdef STOS_BYTE_CNT_EN
            byte_cnt_q  <= byte_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        com_cnt_d = com_cnt_q;
        case (state_q)
            UNLOCKED: begin
                bit_cnt_d = '0;
                if (is_com) begin
                    com_cnt_d = 4'd1;
                    state_d   = ALIGNING;
                end
            end
            ALIGNING: begin
                bit_cnt_d = bit_cnt_inc;
                if (boundary) begin
                    // A miss drops straight back to hunting; no re-check on this same edge
                    if (!is_com) begin
                        state_d   = UNLOCKED;
                        com_cnt_d = '0;
                    end else if (com_cnt_q + 4'd1 == 4'(LOCK_COUNT)) begin
                        state_d   = ACTIVE;
                        com_cnt_d = '0;
                    end else begin
                        com_cnt_d = com_cnt_q + 4'd1;
                    end
                end
            end
            ACTIVE: begin
                bit_cnt_d = bit_cnt_inc;
            end
            default: begin
                state_d   = UNLOCKED;
                bit_cnt_d = '0;
                com_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (state_q == ACTIVE && boundary) begin
            out_d       = sr_d;
            out_valid_d = !is_com;
        end
        active_d = (state_d == ACTIVE);
`ifdef STOS_BYTE_CNT_EN
        byte_cnt_d = byte_cnt_q;
        if (state_q != ACTIVE && state_d == ACTIVE) begin
            byte_cnt_d = '0;
        end else if (out_valid_d && byte_cnt_q != 8'hFF) begin
            byte_cnt_d = byte_cnt_q + 8'd1;
        end
`endif
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign active    = active_q;
`ifdef STOS_BYTE_CNT_EN
    assign byte_cnt  = byte_cnt_q;
`endif

endmodule

// File: tb/tb_serial_to_parallel_align.sv
// Directed bench for serial_to_parallel_align; byte counter checks run when STOS_BYTE_CNT_EN is defined.
module tb_serial_to_parallel_align;

    logic       clk32f;
    logic       reset;
    logic       in;
    logic [7:0] out;
    logic       out_valid;
    logic       active;
`ifdef STOS_BYTE_CNT_EN
    logic [7:0] byte_cnt;
`endif

    int passed = 0;
    int total  = 0;

    serial_to_parallel_align dut (
        .clk32f    (clk32f),
        .reset     (reset),
        .in        (in),
        .out       (out),
        .out_valid (out_valid),
        .active    (active)
`ifdef STOS_BYTE_CNT_EN
        ,
        .byte_cnt  (byte_cnt)
`endif
    );

    initial clk32f = 1'b0;
    always #5 clk32f = ~clk32f;

    task automatic checkOutput(input string tag, input logic [7:0] exp_out,
                               input logic exp_valid, input logic exp_active);
        total++;
        assert (out === exp_out) passed++;
        else $error("FAIL %s out: observed %h expected %h", tag, out, exp_out);
        total++;
        assert (out_valid === exp_valid) passed++;
        else $error("FAIL %s out_valid: observed %b expected %b", tag, out_valid, exp_valid);
        total++;
        assert (active === exp_active) passed++;
        else $error("FAIL %s active: observed %b expected %b", tag, active, exp_active);
    endtask

    task automatic sendBit(input logic b);
        in = b;
        @(posedge clk32f);
        #1;
    endtask

    // Sends one byte MSB-first; the first 7 bits must leave out held, no strobe, active steady
    task automatic applyStimulus(input logic [7:0] b, input logic [7:0] out_hold,
                                 input logic act_pre, input string tag);
        for (int i = 7; i >= 0; i--) begin
            sendBit(b[i]);
            if (i > 0) checkOutput(tag, out_hold, 1'b0, act_pre);
        end
    endtask

    task automatic doReset();
        reset = 1'b0;
        @(posedge clk32f);
        #1;
        checkOutput("reset_pulse", 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        in    = 1'b0;

        $display("[TB] step 1: reset held with input toggling");
        for (int i = 0; i < 3; i++) begin
            in = ~in;
            @(posedge clk32f);
            #1;
            checkOutput("reset_hold", 8'h00, 1'b0, 1'b0);
        end
        reset = 1'b1;

        $display("[TB] step 2: lock on four aligned COMs");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'hBC, 8'h00, 1'b0, "lock_com");
            checkOutput("lock_com_end", 8'h00, 1'b0, 1'b0);
        end
        applyStimulus(8'hBC, 8'h00, 1'b0, "lock_com4");
        checkOutput("lock_done", 8'h00, 1'b0, 1'b1);

        $display("[TB] step 3: data bytes in ACTIVE");
        applyStimulus(8'hA5, 8'h00, 1'b1, "data_a5");
        checkOutput("data_a5_end", 8'hA5, 1'b1, 1'b1);
        applyStimulus(8'h3C, 8'hA5, 1'b1, "data_3c");
        checkOutput("data_3c_end", 8'h3C, 1'b1, 1'b1);
        applyStimulus(8'hBC, 8'h3C, 1'b1, "idle_bc");
        checkOutput("idle_bc_end", 8'hBC, 1'b0, 1'b1);
        applyStimulus(8'h0B, 8'hBC, 1'b1, "span_0b");
        checkOutput("span_0b_end", 8'h0B, 1'b1, 1'b1);
        applyStimulus(8'hC0, 8'h0B, 1'b1, "span_c0");
        checkOutput("span_c0_end", 8'hC0, 1'b1, 1'b1);

        $display("[TB] step 4: lock at shifted phase");
        doReset();
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        checkOutput("shift_pre", 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'hBC, 8'h00, 1'b0, "shift_com");
            checkOutput("shift_com_end", 8'h00, 1'b0, 1'b0);
        end
        applyStimulus(8'hBC, 8'h00, 1'b0, "shift_com4");
        checkOutput("shift_lock", 8'h00, 1'b0, 1'b1);
        applyStimulus(8'h5A, 8'h00, 1'b1, "shift_5a");
        checkOutput("shift_5a_end", 8'h5A, 1'b1, 1'b1);

        $display("[TB] step 5: broken COM run returns to hunting");
        doReset();
        applyStimulus(8'hBC, 8'h00, 1'b0, "brk_com");
        applyStimulus(8'hBC, 8'h00, 1'b0, "brk_com");
        applyStimulus(8'h00, 8'h00, 1'b0, "brk_zero");
        checkOutput("brk_zero_end", 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'hBC, 8'h00, 1'b0, "relock_com");
            checkOutput("relock_com_end", 8'h00, 1'b0, 1'b0);
        end
        applyStimulus(8'hBC, 8'h00, 1'b0, "relock_com4");
        checkOutput("relock_done", 8'h00, 1'b0, 1'b1);
        applyStimulus(8'hC3, 8'h00, 1'b1, "relock_c3");
        checkOutput("relock_c3_end", 8'hC3, 1'b1, 1'b1);

        $display("[TB] step 6: asynchronous reset mid-byte");
        sendBit(1'b1);
        sendBit(1'b1);
        sendBit(1'b0);
        reset = 1'b0;
        #2;
        checkOutput("async_reset", 8'h00, 1'b0, 1'b0);
        @(posedge clk32f);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'hBC, 8'h00, 1'b0, "fresh_com");
            checkOutput("fresh_com_end", 8'h00, 1'b0, 1'b0);
        end
        applyStimulus(8'hBC, 8'h00, 1'b0, "fresh_com4");
        checkOutput("fresh_lock", 8'h00, 1'b0, 1'b1);

`ifdef STOS_BYTE_CNT_EN
        $display("[TB] byte counter saturation");
        total++;
        assert (byte_cnt === 8'h00) passed++;
        else $error("FAIL byte_cnt_lock: observed %h expected %h", byte_cnt, 8'h00);
        for (int n = 0; n < 300; n++) begin
            for (int i = 7; i >= 0; i--) begin
                in = (i == 0);
                @(posedge clk32f);
                #1;
            end
        end
        total++;
        assert (byte_cnt === 8'hFF) passed++;
        else $error("FAIL byte_cnt_sat: observed %h expected %h", byte_cnt, 8'hFF);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
